// File: rtl/tag_anc_pkg.sv
// Shared definitions for the tag receive chain: integrate-and-dump FSM
// encoding, RX controller state encodings and the default sync period length.
package tag_anc_pkg;

    // Integrate-and-dump FSM states.
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ACCUM = 1'b1
    } integ_state_e;

    // rx_state encodings driven by tag_rx_ctrl_tag_chip.
    typedef enum logic [1:0] {
        RX_ST_IDLE = 2'd0,
        RX_ST_SYNC = 2'd1,
        RX_ST_RECV = 2'd2,
        RX_ST_DONE = 2'd3
    } rx_state_e;

    // Samples per sync period in the production configuration.
    localparam int SYNC_SIG_N_DEFAULT = 8192;

endpackage

// File: rtl/tag_rx_integ_fifo.sv
// Synchronous first-word-fall-through FIFO for integrate-and-dump results.
// A push while full is accepted only if a pop happens in the same cycle.
module tag_rx_integ_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    input  logic             pop,
    output logic             empty,
    output logic [WIDTH-1:0] data
);

    localparam int AW = $clog2(DEPTH);

    // Pointers carry one extra wrap bit to tell full from empty.
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign data    = mem_q[rd_ptr_q[AW-1:0]];

    // Pointer update; both pointers return to zero on reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // Storage write.
    always_ff @(posedge clk) begin
        // NOTE: storage is not reset; empty gates its contents, so stale words are never observed.
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
    end

endmodule

// File: rtl/tag_rx_integ_dump.sv
// Integrate-and-dump of signed I/Q samples over one sync period, aligned to
// counter_sync. Each complete period becomes one {I_sum, Q_sum} beat tagged
// with the rx_state captured at period start, delivered through a FWFT FIFO.
// Optional build macro TAG_RX_INTEG_DROP_CNT_EN adds saturating drop_count
// and aborted_count outputs.
module tag_rx_integ_dump
    import tag_anc_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int SYNC_SIG_N = SYNC_SIG_N_DEFAULT,
    parameter int ACC_WIDTH  = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   rx_valid,
    input  logic [DATA_WIDTH-1:0]  irx_in,
    input  logic [DATA_WIDTH-1:0]  qrx_in,
    input  logic [1:0]             rx_state,
    input  logic [DATA_WIDTH-1:0]  counter_sync,
    output logic [2*ACC_WIDTH-1:0] m_tdata,
    output logic [1:0]             m_tuser,
    output logic                   m_tvalid,
    input  logic                   m_tready,
    output logic                   abort_pulse
`ifdef TAG_RX_INTEG_DROP_CNT_EN
    ,
    output logic [15:0]            drop_count,
    output logic [15:0]            aborted_count
`endif
);

    localparam int                    FW       = 2 * ACC_WIDTH + 2;
    localparam logic [DATA_WIDTH-1:0] LAST_IDX = DATA_WIDTH'(SYNC_SIG_N - 1);

    if (SYNC_SIG_N < 2) begin : g_bad_period
        $error("tag_rx_integ_dump: SYNC_SIG_N must be >= 2");
    end
    if (ACC_WIDTH < DATA_WIDTH + $clog2(SYNC_SIG_N)) begin : g_bad_acc
        $error("tag_rx_integ_dump: ACC_WIDTH too narrow for SYNC_SIG_N samples");
    end

    integ_state_e                 state_q;
    logic signed [ACC_WIDTH-1:0]  acc_i_q;
    logic signed [ACC_WIDTH-1:0]  acc_q_q;
    logic [DATA_WIDTH-1:0]        exp_idx_q;
    logic [1:0]                   rx_state_lat_q;
    logic                         abort_q;

    logic signed [ACC_WIDTH-1:0]  i_ext;
    logic signed [ACC_WIDTH-1:0]  q_ext;
    logic signed [ACC_WIDTH-1:0]  sum_i_d;
    logic signed [ACC_WIDTH-1:0]  sum_q_d;
    logic                         start_ok;
    logic                         in_seq;
    logic                         seq_err;
    logic                         dump;

    logic                         fifo_full;
    logic                         fifo_empty;
    logic                         fifo_pop;
    logic [FW-1:0]                fifo_dout;

    // Sample qualification and running sums for the current cycle.
    always_comb begin
        // NOTE: every always_comb output is assigned on every path, so no latch can be inferred.
        i_ext    = {{(ACC_WIDTH-DATA_WIDTH){irx_in[DATA_WIDTH-1]}}, irx_in};
        q_ext    = {{(ACC_WIDTH-DATA_WIDTH){qrx_in[DATA_WIDTH-1]}}, qrx_in};
        sum_i_d  = acc_i_q + i_ext;
        sum_q_d  = acc_q_q + q_ext;
        start_ok = rx_valid && (counter_sync == '0);
        in_seq   = (state_q == ST_ACCUM) && rx_valid &&
                   (counter_sync == exp_idx_q) && (rx_state == rx_state_lat_q);
        seq_err  = (state_q == ST_ACCUM) && rx_valid && !in_seq;
        dump     = in_seq && (counter_sync == LAST_IDX);
    end

    // Integrate-and-dump FSM with registered accumulators and abort pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            acc_i_q        <= '0;
            acc_q_q        <= '0;
            exp_idx_q      <= '0;
            rx_state_lat_q <= '0;
            abort_q        <= 1'b0;
        end else begin
            abort_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start_ok) begin
                        acc_i_q        <= i_ext;
                        acc_q_q        <= q_ext;
                        exp_idx_q      <= DATA_WIDTH'(1);
                        rx_state_lat_q <= rx_state;
                        state_q        <= ST_ACCUM;
                    end
                end
                ST_ACCUM: begin
                    if (in_seq) begin
                        acc_i_q   <= sum_i_d;
                        acc_q_q   <= sum_q_d;
                        exp_idx_q <= exp_idx_q + DATA_WIDTH'(1);
                        if (dump) state_q <= ST_IDLE;
                    end else if (seq_err) begin
                        abort_q <= 1'b1;
                        // An out-of-order index 0 opens a fresh period immediately.
                        if (start_ok) begin
                            acc_i_q        <= i_ext;
                            acc_q_q        <= q_ext;
                            exp_idx_q      <= DATA_WIDTH'(1);
                            rx_state_lat_q <= rx_state;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign fifo_pop = m_tvalid && m_tready;

    tag_rx_integ_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (dump),
        .din   ({sum_i_d, sum_q_d, rx_state_lat_q}),
        .full  (fifo_full),
        .pop   (fifo_pop),
        .empty (fifo_empty),
        .data  (fifo_dout)
    );

    // Outputs read as zero whenever no beat is pending.
    assign m_tvalid            = !fifo_empty;
    assign {m_tdata, m_tuser}  = fifo_empty ? '0 : fifo_dout;
    assign abort_pulse         = abort_q;

`ifdef TAG_RX_INTEG_DROP_CNT_EN
    logic        drop;
    logic [15:0] drop_count_q;
    logic [15:0] aborted_count_q;

    assign drop = dump && fifo_full && !fifo_pop;

    // Saturating event counters for dropped results and aborted periods.
    always_ff @(posedge clk) begin
        if (reset) begin
            drop_count_q    <= '0;
            aborted_count_q <= '0;
        end else begin
            if (drop && drop_count_q != 16'hFFFF)       drop_count_q    <= drop_count_q + 16'd1;
            if (seq_err && aborted_count_q != 16'hFFFF) aborted_count_q <= aborted_count_q + 16'd1;
        end
    end

    assign drop_count    = drop_count_q;
    assign aborted_count = aborted_count_q;
`endif

endmodule

// File: tb/tb_tag_rx_integ_dump.sv
// Scoreboard bench for tag_rx_integ_dump with a short sync period (256
// samples). Stimulus pushes expected beats; a negedge monitor pops and compares.
module tb_tag_rx_integ_dump;
    import tag_anc_pkg::*;

    localparam int DW    = 16;
    localparam int N     = 256;
    localparam int AW    = 32;
    localparam int DEPTH = 4;

    logic            clk;
    logic            reset;
    logic            rx_valid;
    logic [DW-1:0]   irx_in;
    logic [DW-1:0]   qrx_in;
    logic [1:0]      rx_state;
    logic [DW-1:0]   counter_sync;
    logic [2*AW-1:0] m_tdata;
    logic [1:0]      m_tuser;
    logic            m_tvalid;
    logic            m_tready;
    logic            abort_pulse;
`ifdef TAG_RX_INTEG_DROP_CNT_EN
    logic [15:0]     drop_count;
    logic [15:0]     aborted_count;
`endif

    tag_rx_integ_dump #(
        .DATA_WIDTH (DW),
        .SYNC_SIG_N (N),
        .ACC_WIDTH  (AW),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .rx_valid     (rx_valid),
        .irx_in       (irx_in),
        .qrx_in       (qrx_in),
        .rx_state     (rx_state),
        .counter_sync (counter_sync),
        .m_tdata      (m_tdata),
        .m_tuser      (m_tuser),
        .m_tvalid     (m_tvalid),
        .m_tready     (m_tready),
        .abort_pulse  (abort_pulse)
`ifdef TAG_RX_INTEG_DROP_CNT_EN
        ,
        .drop_count   (drop_count),
        .aborted_count(aborted_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2*AW-1:0] data;
        logic [1:0]      user;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   abort_seen = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [2*AW-1:0] exp_data(input int iv, input int qv);
        int si;
        int sq;
        si = iv * N;
        sq = qv * N;
        return {si, sq};
    endfunction

    // One clock of stimulus; returns 1 time unit after the active edge.
    task automatic drive(input logic v, input int iv, input int qv, input logic [1:0] st, input int idx);
        logic [31:0] iw;
        logic [31:0] qw;
        logic [31:0] xw;
        iw = iv;
        qw = qv;
        xw = idx;
        rx_valid     = v;
        irx_in       = iw[DW-1:0];
        qrx_in       = qw[DW-1:0];
        rx_state     = st;
        counter_sync = xw[DW-1:0];
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(1'b0, 0, 0, 2'd0, 0);
    endtask

    task automatic run_period(input int iv, input int qv, input logic [1:0] st,
                              input bit gaps, input bit expect_beat, input bit chk_early);
        exp_t e;
        for (int k = 0; k < N; k++) begin
            if (k == N - 1) begin
                if (chk_early) check("no_beat_before_last", m_tvalid, 0);
                if (expect_beat) begin
                    e.data = exp_data(iv, qv);
                    e.user = st;
                    sb.push_back(e);
                end
            end
            drive(1'b1, iv, qv, st, k);
            if (gaps && k != N - 1) drive(1'b0, 7, -7, ~st, 16'hABCD);
        end
    endtask

    task automatic drain(input string name);
        for (int k = 0; k < 40 && sb.size() != 0; k++) idle(1);
        idle(1);
        check(name, sb.size(), 0);
    endtask

    // Monitor: scoreboard compare on transfer, stability check while stalled.
    bit              stalled_q = 0;
    logic [2*AW-1:0] held_data;
    logic [1:0]      held_user;
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            stalled_q = 0;
        end else begin
            if (abort_pulse) abort_seen++;
            if (stalled_q) begin
                check("stall_valid", m_tvalid, 1);
                check("stall_data", m_tdata, held_data);
                check("stall_user", m_tuser, held_user);
            end
            if (m_tvalid && m_tready) begin
                if (sb.size() == 0) begin
                    check("unexpected_beat", m_tvalid, 0);
                end else begin
                    e = sb.pop_front();
                    check("beat_data", m_tdata, e.data);
                    check("beat_user", m_tuser, e.user);
                end
            end
            stalled_q = m_tvalid && !m_tready;
            held_data = m_tdata;
            held_user = m_tuser;
        end
    end

    initial begin
        int ab;
        reset    = 1'b1;
        m_tready = 1'b1;
        idle(3);
        check("rst_tvalid", m_tvalid, 0);
        check("rst_tdata", m_tdata, 0);
        check("rst_tuser", m_tuser, 0);
        check("rst_abort", abort_pulse, 0);
        reset = 1'b0;
        idle(2);

        // 1: steady samples, one beat one cycle after the last sample.
        run_period(16000, -16000, RX_ST_RECV, 1'b0, 1'b1, 1'b1);
        check("t1_latency_valid", m_tvalid, 1);
        drain("t1_drain");
        check("t1_no_abort", abort_seen, 0);

        // 2: 1:1 valid gaps give identical sums.
        run_period(16000, -16000, RX_ST_SYNC, 1'b1, 1'b1, 1'b1);
        drain("t2_drain");

        // 3: index jump aborts once, no beat; next period sums correctly.
        ab = abort_seen;
        for (int k = 0; k <= 100; k++) drive(1'b1, 500, 500, RX_ST_RECV, k);
        drive(1'b1, 500, 500, RX_ST_RECV, 102);
        for (int k = 103; k < 110; k++) drive(1'b1, 500, 500, RX_ST_RECV, k);
        idle(1);
        check("t3_abort_once", abort_seen, ab + 1);
        check("t3_no_beat", m_tvalid, 0);
        run_period(123, -7, RX_ST_DONE, 1'b0, 1'b1, 1'b1);
        drain("t3_drain");
        check("t3_no_more_abort", abort_seen, ab + 1);

        // 4: stall over 5 periods; 4 held, 5th dropped, then released in order.
        m_tready = 1'b0;
        for (int k = 0; k < 5; k++)
            run_period((k + 1) * 100, -(k + 1) * 3, 2'(k), 1'b0, k < DEPTH, 1'b0);
        idle(2);
        check("t4_held_valid", m_tvalid, 1);
        check("t4_held_oldest", m_tdata, exp_data(100, -3));
`ifdef TAG_RX_INTEG_DROP_CNT_EN
        check("t4_drop_count", drop_count, 1);
`endif
        m_tready = 1'b1;
        drain("t4_drain");
        check("t4_empty_after", m_tvalid, 0);

        // 5: reset mid-stall and mid-period flushes everything.
        ab = abort_seen;
        m_tready = 1'b0;
        run_period(1000, 1000, RX_ST_SYNC, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k <= 100; k++) drive(1'b1, 300, -300, RX_ST_SYNC, k);
        reset = 1'b1;
        idle(1);
        check("t5_rst_tvalid", m_tvalid, 0);
        check("t5_rst_tdata", m_tdata, 0);
        check("t5_rst_tuser", m_tuser, 0);
        check("t5_rst_abort", abort_pulse, 0);
`ifdef TAG_RX_INTEG_DROP_CNT_EN
        check("t5_rst_drop_count", drop_count, 0);
        check("t5_rst_aborted_count", aborted_count, 0);
`endif
        reset    = 1'b0;
        m_tready = 1'b1;
        for (int k = 101; k < 110; k++) drive(1'b1, 300, -300, RX_ST_SYNC, k);
        check("t5_nothing_emitted", m_tvalid, 0);
        run_period(-5, 7, RX_ST_SYNC, 1'b0, 1'b1, 1'b1);
        drain("t5_drain");
        check("t5_no_abort", abort_seen, ab);

        // 6: mid-period start ignored, state change aborts, full-scale negative.
        ab = abort_seen;
        for (int k = 17; k <= 30; k++) drive(1'b1, 1, 1, RX_ST_SYNC, k);
        idle(1);
        check("t6_start17_ignored", abort_seen, ab);
        check("t6_start17_no_beat", m_tvalid, 0);
        for (int k = 0; k <= 50; k++) drive(1'b1, 1, 1, RX_ST_SYNC, k);
        drive(1'b1, 1, 1, RX_ST_RECV, 51);
        idle(1);
        check("t6_state_abort", abort_seen, ab + 1);
        run_period(-32768, 32767, RX_ST_IDLE, 1'b0, 1'b1, 1'b1);
        drain("t6_drain");

        // 7: out-of-order index 0 aborts and restarts in the same cycle.
        ab = abort_seen;
        for (int k = 0; k <= 40; k++) drive(1'b1, 9, 9, RX_ST_DONE, k);
        run_period(11, -2, RX_ST_DONE, 1'b0, 1'b1, 1'b1);
        drain("t7_drain");
        check("t7_abort_restart", abort_seen, ab + 1);
`ifdef TAG_RX_INTEG_DROP_CNT_EN
        check("t7_aborted_count", aborted_count, 2);
        check("t7_drop_count", drop_count, 0);
`endif

        idle(3);
        check("final_sb_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
